// File: rtl/wb_retire_queue.sv
// wb_retire_queue: DEPTH-entry in-order retire queue between MEM and the
// register file. One entry retires per cycle when the RF write port grants
// rf_ready. Provides byte-enabled RF writes, trace-debug outputs, two-port
// forwarding over every queued result, and a free-running retire counter.
module wb_retire_queue #(
    parameter  int DATA_W = 32,
    parameter  int ADDR_W = 5,
    parameter  int DEPTH  = 4,
    parameter  int PC_W   = 32,
    localparam int BE_W   = DATA_W / 8,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = PTR_W + 1
) (
    input  logic              clk,
    input  logic              reset,
    // MEM -> WB handshake and payload
    input  logic              ms_to_ws_valid,
    output logic              ws_allowin,
    input  logic [BE_W-1:0]   ms_gr_we,
    input  logic [ADDR_W-1:0] ms_dest,
    input  logic [DATA_W-1:0] ms_result,
    input  logic [PC_W-1:0]   ms_pc,
    // register-file write port
    input  logic              rf_ready,
    output logic [BE_W-1:0]   rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    // trace debug
    output logic [PC_W-1:0]   debug_wb_pc,
    output logic [BE_W-1:0]   debug_wb_rf_wen,
    output logic [ADDR_W-1:0] debug_wb_rf_wnum,
    output logic [DATA_W-1:0] debug_wb_rf_wdata,
    // forwarding lookup for ID
    input  logic [ADDR_W-1:0] ds_raddr0,
    input  logic [ADDR_W-1:0] ds_raddr1,
    output logic              fwd_hit0,
    output logic              fwd_hit1,
    output logic [DATA_W-1:0] fwd_data0,
    output logic [DATA_W-1:0] fwd_data1,
    output logic              fwd_stall0,
    output logic              fwd_stall1,
    // status
    output logic [CNT_W-1:0]  ws_count,
    output logic [31:0]       retire_cnt
);

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [BE_W-1:0]   we;
        logic [ADDR_W-1:0] dest;
        logic [DATA_W-1:0] result;
    } entry_t;

    typedef struct packed {
        logic              hit;
        logic              stall;
        logic [DATA_W-1:0] data;
    } fwd_t;

    entry_t            mem [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;
    logic              empty;
    logic              enq;
    logic              deq;
    entry_t            head_e;
    fwd_t              fwd0;
    fwd_t              fwd1;

    assign empty      = (count == '0);
    // Reset suppresses retirement so nothing reaches the RF in the reset cycle.
    assign deq        = !reset && !empty && rf_ready;
    // A full queue still accepts when its head retires in the same cycle.
    assign ws_allowin = (count < CNT_W'(DEPTH)) || deq;
    assign enq        = ms_to_ws_valid && ws_allowin;
    assign head_e     = mem[head];
    assign ws_count   = count;

    assign rf_we             = head_e.we & {BE_W{deq}};
    assign rf_waddr          = empty ? '0 : head_e.dest;
    assign rf_wdata          = empty ? '0 : head_e.result;
    assign debug_wb_pc       = empty ? '0 : head_e.pc;
    assign debug_wb_rf_wen   = rf_we;
    assign debug_wb_rf_wnum  = rf_waddr;
    assign debug_wb_rf_wdata = rf_wdata;

    // Scan oldest to youngest so the youngest valid match is the one kept.
    function automatic fwd_t lookup(input logic [ADDR_W-1:0] raddr);
        fwd_t             r;
        logic [PTR_W-1:0] idx;
        r = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if ((CNT_W'(i) < count) && (raddr != '0) &&
                (mem[idx].dest == raddr) && (mem[idx].we != '0)) begin
                r.hit   = &mem[idx].we;
                r.stall = ~&mem[idx].we;
                r.data  = (&mem[idx].we) ? mem[idx].result : '0;
            end
        end
        return r;
    endfunction

    // Combinational forwarding lookup for both ID source ports
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
        fwd0 = '0;
        fwd1 = '0;
        fwd0 = lookup(ds_raddr0);
        fwd1 = lookup(ds_raddr1);
    end

    assign fwd_hit0   = fwd0.hit;
    assign fwd_stall0 = fwd0.stall;
    assign fwd_data0  = fwd0.data;
    assign fwd_hit1   = fwd1.hit;
    assign fwd_stall1 = fwd1.stall;
    assign fwd_data1  = fwd1.data;

    // Entry storage write at the tail on enqueue
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; validity comes from count, so stale entries are never observed.
        if (enq) begin
            mem[tail] <= '{pc: ms_pc, we: ms_gr_we, dest: ms_dest, result: ms_result};
        end
    end

    // Pointer, occupancy and retire-counter update
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            retire_cnt <= '0;
        end else begin
            if (enq) tail <= tail + PTR_W'(1);
            if (deq) begin
                head       <= head + PTR_W'(1);
                retire_cnt <= retire_cnt + 32'd1;
            end
            case ({enq, deq})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_retire_queue.sv
// tb_wb_retire_queue: scoreboard bench for wb_retire_queue. Stimulus pushes
// each accepted instruction's expected retirement into a queue; a monitor
// pops and compares on every retire cycle. Directed checks cover occupancy,
// forwarding, retire counting and reset.
module tb_wb_retire_queue;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 4;
    localparam int PC_W   = 32;
    localparam int BE_W   = 4;

    logic              clk;
    logic              reset;
    logic              ms_to_ws_valid;
    logic              ws_allowin;
    logic [BE_W-1:0]   ms_gr_we;
    logic [ADDR_W-1:0] ms_dest;
    logic [DATA_W-1:0] ms_result;
    logic [PC_W-1:0]   ms_pc;
    logic              rf_ready;
    logic [BE_W-1:0]   rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic [PC_W-1:0]   debug_wb_pc;
    logic [BE_W-1:0]   debug_wb_rf_wen;
    logic [ADDR_W-1:0] debug_wb_rf_wnum;
    logic [DATA_W-1:0] debug_wb_rf_wdata;
    logic [ADDR_W-1:0] ds_raddr0;
    logic [ADDR_W-1:0] ds_raddr1;
    logic              fwd_hit0;
    logic              fwd_hit1;
    logic [DATA_W-1:0] fwd_data0;
    logic [DATA_W-1:0] fwd_data1;
    logic              fwd_stall0;
    logic              fwd_stall1;
    logic [2:0]        ws_count;
    logic [31:0]       retire_cnt;

    typedef struct {
        logic [31:0] pc;
        logic [3:0]  we;
        logic [4:0]  dest;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    wb_retire_queue #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .PC_W(PC_W)
    ) dut (
        .clk(clk), .reset(reset),
        .ms_to_ws_valid(ms_to_ws_valid), .ws_allowin(ws_allowin),
        .ms_gr_we(ms_gr_we), .ms_dest(ms_dest), .ms_result(ms_result), .ms_pc(ms_pc),
        .rf_ready(rf_ready), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
        .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata),
        .ds_raddr0(ds_raddr0), .ds_raddr1(ds_raddr1),
        .fwd_hit0(fwd_hit0), .fwd_hit1(fwd_hit1),
        .fwd_data0(fwd_data0), .fwd_data1(fwd_data1),
        .fwd_stall0(fwd_stall0), .fwd_stall1(fwd_stall1),
        .ws_count(ws_count), .retire_cnt(retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Offer one instruction from MEM; record it as expected once accepted.
    task automatic enqueue(input logic [31:0] pc, input logic [3:0] we,
                           input logic [4:0] dest, input logic [31:0] data);
        exp_t e;
        int   waited;
        ms_to_ws_valid = 1'b1;
        ms_pc          = pc;
        ms_gr_we       = we;
        ms_dest        = dest;
        ms_result      = data;
        waited         = 0;
        @(negedge clk);
        while (!ws_allowin && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        if (!ws_allowin) begin
            check("enqueue_timeout", 64'd0, 64'd1);
        end else begin
            @(posedge clk);
            e.pc = pc; e.we = we; e.dest = dest; e.data = data;
            exp_q.push_back(e);
        end
        #1 ms_to_ws_valid = 1'b0;
    endtask

    // Let the queue retire until empty, bounded.
    task automatic drain();
        int n;
        n = 0;
        rf_ready = 1'b1;
        @(negedge clk);
        while (ws_count != 0 && n < 20) begin
            n++;
            @(negedge clk);
        end
        check("drain_empty", 64'(ws_count), 64'd0);
        @(posedge clk);
        #1 rf_ready = 1'b0;
    endtask

    // Monitor: every retire cycle pops one expectation and compares outputs.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && rf_ready && ws_count != 0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_retire", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("ret_pc",      64'(debug_wb_pc),       64'(e.pc));
                    check("ret_rf_we",   64'(rf_we),             64'(e.we));
                    check("ret_waddr",   64'(rf_waddr),          64'(e.dest));
                    check("ret_wdata",   64'(rf_wdata),          64'(e.data));
                    check("ret_dbg_wen", 64'(debug_wb_rf_wen),   64'(e.we));
                    check("ret_dbg_num", 64'(debug_wb_rf_wnum),  64'(e.dest));
                    check("ret_dbg_dat", 64'(debug_wb_rf_wdata), 64'(e.data));
                end
            end
        end
    end

    initial begin
        reset = 1'b1; ms_to_ws_valid = 1'b0; ms_gr_we = '0; ms_dest = '0;
        ms_result = '0; ms_pc = '0; rf_ready = 1'b0; ds_raddr0 = '0; ds_raddr1 = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_count",      64'(ws_count),    64'd0);
        check("rst_allowin",    64'(ws_allowin),  64'd1);
        check("rst_rf_we",      64'(rf_we),       64'd0);
        check("rst_waddr",      64'(rf_waddr),    64'd0);
        check("rst_dbg_pc",     64'(debug_wb_pc), 64'd0);
        check("rst_retire_cnt", 64'(retire_cnt),  64'd0);
        check("rst_fwd_hit0",   64'(fwd_hit0),    64'd0);
        check("rst_fwd_data0",  64'(fwd_data0),   64'd0);
        @(posedge clk);
        #1;

        // Streaming retire with rf_ready held: one-cycle latency, in order
        rf_ready = 1'b1;
        enqueue(32'h1c000000, 4'hF, 5'd1, 32'hA1);
        @(negedge clk);
        check("lat1_rf_we", 64'(rf_we),    64'hF);
        check("lat1_waddr", 64'(rf_waddr), 64'd1);
        @(posedge clk);
        #1;
        enqueue(32'h1c000004, 4'hF, 5'd2, 32'hA2);
        enqueue(32'h1c000008, 4'hF, 5'd3, 32'hA3);
        @(negedge clk);
        @(negedge clk);
        check("t1_count",      64'(ws_count),   64'd0);
        check("t1_retire_cnt", 64'(retire_cnt), 64'd3);
        @(posedge clk);
        #1 rf_ready = 1'b0;

        // Full queue back-pressure, then simultaneous retire and accept
        for (int i = 0; i < 4; i++)
            enqueue(32'h1c000100 + 32'(4 * i), 4'hF, 5'(8 + i), 32'h100 + 32'(i));
        ms_to_ws_valid = 1'b1; ms_pc = 32'h1c000110; ms_gr_we = 4'hF;
        ms_dest = 5'd12; ms_result = 32'h104;
        @(negedge clk);
        check("full_count",   64'(ws_count),   64'd4);
        check("full_allowin", 64'(ws_allowin), 64'd0);
        @(posedge clk);
        #1 rf_ready = 1'b1;
        @(negedge clk);
        check("full_deq_allowin", 64'(ws_allowin), 64'd1);
        @(posedge clk);
        begin
            exp_t e5;
            e5.pc = 32'h1c000110; e5.we = 4'hF; e5.dest = 5'd12; e5.data = 32'h104;
            exp_q.push_back(e5);
        end
        #1 ms_to_ws_valid = 1'b0;
        rf_ready = 1'b0;
        @(negedge clk);
        check("full_swap_count", 64'(ws_count), 64'd4);
        check("full_idle_rf_we", 64'(rf_we),    64'd0);
        @(posedge clk);
        #1;
        drain();
        check("t2_retire_cnt", 64'(retire_cnt), 64'd8);

        // Forwarding: youngest full-word match wins, port 1 register 0 never hits
        enqueue(32'h1c000300, 4'hF, 5'd5, 32'h11);
        enqueue(32'h1c000304, 4'hF, 5'd5, 32'h22);
        ds_raddr0 = 5'd5; ds_raddr1 = 5'd0;
        @(negedge clk);
        check("fwd_hit0",    64'(fwd_hit0),   64'd1);
        check("fwd_data0",   64'(fwd_data0),  64'h22);
        check("fwd_stall0",  64'(fwd_stall0), 64'd0);
        check("fwd_r0_hit1", 64'(fwd_hit1),   64'd0);
        check("fwd_r0_dat1", 64'(fwd_data1),  64'd0);
        check("fwd_r0_stl1", 64'(fwd_stall1), 64'd0);
        @(posedge clk);
        #1;

        // Forwarding: youngest partial-byte match stalls
        enqueue(32'h1c000308, 4'hF, 5'd7, 32'h77);
        enqueue(32'h1c00030c, 4'h3, 5'd7, 32'h33);
        ds_raddr0 = 5'd7; ds_raddr1 = 5'd5;
        @(negedge clk);
        check("part_stall0", 64'(fwd_stall0), 64'd1);
        check("part_hit0",   64'(fwd_hit0),   64'd0);
        check("part_hit1",   64'(fwd_hit1),   64'd1);
        check("part_data1",  64'(fwd_data1),  64'h22);
        @(posedge clk);
        #1;
        drain();
        check("t4_retire_cnt", 64'(retire_cnt), 64'd12);

        // No-write entry still retires through the trace port
        enqueue(32'h1c000010, 4'h0, 5'd4, 32'h55);
        ds_raddr0 = 5'd4; ds_raddr1 = 5'd0;
        @(negedge clk);
        check("nowe_fwd_hit0",   64'(fwd_hit0),   64'd0);
        check("nowe_fwd_stall0", 64'(fwd_stall0), 64'd0);
        @(posedge clk);
        #1 rf_ready = 1'b1;
        @(negedge clk);
        check("nowe_dbg_pc",  64'(debug_wb_pc),     64'h1c000010);
        check("nowe_dbg_wen", 64'(debug_wb_rf_wen), 64'd0);
        @(posedge clk);
        #1 rf_ready = 1'b0;
        @(negedge clk);
        check("nowe_retire_cnt", 64'(retire_cnt), 64'd13);
        check("nowe_count",      64'(ws_count),   64'd0);
        @(posedge clk);
        #1;

        // Reset with entries queued discards them without writing
        for (int i = 0; i < 3; i++)
            enqueue(32'h1c000200 + 32'(4 * i), 4'hF, 5'(20 + i), 32'h200 + 32'(i));
        @(negedge clk);
        check("prerst_count", 64'(ws_count), 64'd3);
        @(posedge clk);
        #1 reset = 1'b1;
        rf_ready = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("rstcyc_rf_we", 64'(rf_we), 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("mrst_count",      64'(ws_count),   64'd0);
        check("mrst_rf_we",      64'(rf_we),      64'd0);
        check("mrst_retire_cnt", 64'(retire_cnt), 64'd0);
        check("mrst_allowin",    64'(ws_allowin), 64'd1);
        @(negedge clk);
        check("mrst_idle_rf_we", 64'(rf_we), 64'd0);

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
